ir_receiver: RTL and testbench
==============================

// Module: ir_receiver
// PURPOSE
//  Bus-mapped IR packet decoder. It is the receive end of the car remote link.
//  It takes the carrier-modulated IR photodiode signal and envelope-detects bursts.
//  It measures each burst in carrier cycles and decodes the packet:
//  START, CAR_SELECT, RIGHT, LEFT, BACKWARD, FORWARD.
//  The 4-bit command is exposed on the microprocessor bus, with an interrupt on each new packet.
// PARAMETERS
//  BASE_ADDR     8'h92   COMMAND reg; STATUS reg at BASE_ADDR+1
//  START_LEN     191     start burst length, carrier cycles
//  CARSEL_LEN    47      car-select burst length, carrier cycles
//  ASSERT_LEN    47      data burst length meaning 1
//  DEASSERT_LEN  22      data burst length meaning 0
//  TOL           4       +/- tolerance on every burst length match
//  ENV_TIMEOUT   5600    clocks without a carrier rising edge -> envelope low
//  GAP_TIMEOUT   280000  clocks of envelope low mid-packet -> abort
// PORTS
//  CLK                  in     1  system clock (100 MHz)
//  RESET                in     1  synchronous, active-high
//  IR_IN                in     1  raw modulated IR input, asynchronous
//  BUS_ADDR             in     8  bus address
//  BUS_DATA             inout  8  bus data; driven only during reads of own regs
//  BUS_WE               in     1  bus write enable
//  BUS_INTERRUPT_RAISE  out    1  high from packet decoded until ACK
//  BUS_INTERRUPT_ACK    in     1  processor acknowledge
// BEHAVIOUR
//  Input path
//  - IR_IN passes through a 2-FF synchroniser. Rising edges are detected on the synchronised signal.
//  - Envelope: a counter clears on each rising edge and saturates at ENV_TIMEOUT.
//    env = (cnt < ENV_TIMEOUT).
//  - Burst length = carrier rising edges counted while env=1, saturating 8-bit counter.
//    The length is latched on the env 1->0 transition; that transition is the burst-end event.
//  Classification, each a closed interval [LEN-TOL, LEN+TOL]:
//  - START, CARSEL, ONE, ZERO.
//  - If intervals overlap, match priority is the expected class for the current state.
//  FSM
//  - IDLE -> CARSEL: on a START-class burst end.
//  - CARSEL -> BITS: on a CARSEL-class burst; any other class goes to IDLE with an error.
//  - BITS: takes 4 bursts in order R, L, B, F into shift[3:0] as {F,B,L,R}.
//    ONE gives 1 and ZERO gives 0; any other class goes to IDLE with an error.
//  - After the 4th bit, the FSM goes to DONE for one cycle, then returns to IDLE.
//  - In any non-IDLE state, if env is low for GAP_TIMEOUT clocks, the FSM goes to IDLE with an error.
//  - In IDLE, non-START bursts are ignored silently (no error).
//  DONE actions
//  - COMMAND <= shift.
//  - If VALID is already 1, OVR <= 1.
//  - VALID <= 1.
//  - BUS_INTERRUPT_RAISE <= 1.
//  Errors
//  - err_cnt[3:0] increments on each error and saturates at 15.
//  Registers
//  - COMMAND @BASE = {4'b0, cmd}.
//  - STATUS @BASE+1 = {VALID, OVR, 2'b0, err_cnt}.
//  Bus read
//  - Data and output enable are registered: BUS_DATA is driven in the cycle after the address match with BUS_WE=0.
//  - Otherwise BUS_DATA is high-Z.
//  - A read of COMMAND clears VALID and OVR on the following cycle.
//  Bus write
//  - Any write to BASE+1 clears VALID, OVR and err_cnt.
//  - Writes to BASE are ignored.
//  Interrupt
//  - BUS_INTERRUPT_RAISE clears on BUS_INTERRUPT_ACK.
//  - If DONE and ACK occur in the same cycle, raise wins (stays 1).
//  Collisions
//  - If DONE coincides with a COMMAND read or STATUS clear, the new packet wins: VALID=1 and the new cmd is kept.
//  - If an error coincides with a STATUS clear, err_cnt = 0 (the clear wins).
//  Reset (RESET=1 at a CLK edge)
//  - FSM to IDLE; all counters 0; COMMAND=0; VALID=0; OVR=0; err_cnt=0.
//  - BUS_INTERRUPT_RAISE=0; BUS_DATA high-Z; synchroniser to 0.
//  - A reset mid-packet discards the partial packet; no error is counted.
// TESTING (36 kHz carrier square wave; packet gaps = 25 carrier periods)
//  1. Packet 191/47/47/22/22/47 (F=1, B=0, L=0, R=1) ->
//     COMMAND=0x09, STATUS=0x80, IRQ raised once; read BASE -> 0x09, then STATUS=0x00.
//  2. Start burst of 120 cycles, then data bursts -> no decode, err_cnt=0, IRQ stays 0.
//  3. Valid header, then a 35-cycle burst in R -> err_cnt=1, FSM IDLE;
//     the next good packet decodes normally.
//  4. Two packets with no read in between (cmd 0x03 then 0x0C) ->
//     COMMAND=0x0C, STATUS=0xC0; write BASE+1 -> STATUS=0x00.
//  5. Carrier stops after the L bit for > GAP_TIMEOUT -> err_cnt +1, no IRQ;
//     16 such aborts -> err_cnt=15 (saturates).
//  6. RESET asserted mid-BITS -> all outputs at reset values, BUS_DATA high-Z;
//     a full packet afterwards decodes correctly.
//     Also: ACK in the DONE cycle -> IRQ stays 1.

Source files
------------

// File: rtl/ir_receiver.sv
// -----------------------------------------------------------------------------
// ir_receiver
//   Receive end of the car remote IR link. The raw carrier-modulated photodiode
//   signal is synchronised, envelope-detected and every burst is measured in
//   carrier cycles. A packet is START, CAR_SELECT, then four data bursts in the
//   order RIGHT, LEFT, BACKWARD, FORWARD. Each decoded packet lands in the
//   COMMAND register and raises the bus interrupt.
//
//   Register map
//     BASE_ADDR     COMMAND  {4'b0, cmd}                      read clears VALID/OVR
//     BASE_ADDR+1   STATUS   {VALID, OVR, 2'b0, err_cnt}      any write clears all
//
//   Ports
//     CLK                  in     system clock
//     RESET                in     synchronous, active-high reset
//     IR_IN                in     raw modulated IR input (asynchronous)
//     BUS_ADDR[7:0]        in     bus address
//     BUS_DATA[7:0]        inout  bus data, driven only in the cycle after a
//                                 read of one of our own registers
//     BUS_WE               in     bus write enable
//     BUS_INTERRUPT_RAISE  out    set when a packet is decoded, cleared by ACK
//     BUS_INTERRUPT_ACK    in     processor acknowledge
// -----------------------------------------------------------------------------
module ir_receiver #(
    parameter logic [7:0] BASE_ADDR    = 8'h92,
    parameter int         START_LEN    = 191,
    parameter int         CARSEL_LEN   = 47,
    parameter int         ASSERT_LEN   = 47,
    parameter int         DEASSERT_LEN = 22,
    parameter int         TOL          = 4,
    parameter int         ENV_TIMEOUT  = 5600,
    parameter int         GAP_TIMEOUT  = 280000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       IR_IN,
    input  logic [7:0] BUS_ADDR,
    inout  wire  [7:0] BUS_DATA,
    input  logic       BUS_WE,
    output logic       BUS_INTERRUPT_RAISE,
    input  logic       BUS_INTERRUPT_ACK
);

    localparam int ENV_W = $clog2(ENV_TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);

    localparam logic [ENV_W-1:0] ENV_MAX = ENV_W'(ENV_TIMEOUT);
    localparam logic [ENV_W-1:0] ENV_ONE = ENV_W'(1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_TIMEOUT);
    localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

    localparam logic [7:0] STATUS_ADDR = BASE_ADDR + 8'd1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CARSEL = 2'd1,
        ST_BITS   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Closed-interval length match: target-TOL <= len <= target+TOL.
    function automatic logic len_match(input logic [7:0] len, input int target);
        int lo;
        int hi;
        int val;
        lo  = target - TOL;
        hi  = target + TOL;
        val = int'(len);
        len_match = (val >= lo) && (val <= hi);
    endfunction

    // ---------------------------------------------------------------------
    // Signals
    // ---------------------------------------------------------------------
    logic             ir_meta_r;
    logic             ir_sync_r;
    logic             ir_prev_r;
    logic             carrier_rise_s;

    logic [ENV_W-1:0] env_cnt_r;
    logic             env_s;
    logic             env_prev_r;
    logic             env_fall_s;

    logic [7:0]       burst_cnt_r;
    logic [7:0]       burst_len_r;
    logic             burst_evt_r;

    logic             is_start_s;
    logic             is_carsel_s;
    logic             is_one_s;
    logic             is_zero_s;

    logic [GAP_W-1:0] gap_cnt_r;
    logic             gap_expired_s;

    state_t           state_r;
    state_t           next_state_s;
    logic             err_s;
    logic             done_s;
    logic             bit_we_s;
    logic             bit_val_s;
    logic [1:0]       bit_idx_r;
    logic [3:0]       shift_r;

    logic [3:0]       cmd_r;
    logic             valid_r;
    logic             ovr_r;
    logic [3:0]       err_cnt_r;
    logic             irq_r;

    logic             cmd_read_s;
    logic             status_read_s;
    logic             status_write_s;
    logic             rd_oe_r;
    logic [7:0]       rd_data_r;

    // ---------------------------------------------------------------------
    // Input path
    // ---------------------------------------------------------------------

    // Two-flop synchroniser plus one history flop for rising-edge detection.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ir_meta_r <= 1'b0;
            ir_sync_r <= 1'b0;
            ir_prev_r <= 1'b0;
        end else begin
            ir_meta_r <= IR_IN;
            ir_sync_r <= ir_meta_r;
            ir_prev_r <= ir_sync_r;
        end
    end

    assign carrier_rise_s = ir_sync_r & ~ir_prev_r;

    // Envelope counter: cleared by every carrier edge, saturates at the timeout.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            env_cnt_r <= '0;
        end else if (carrier_rise_s) begin
            env_cnt_r <= '0;
        end else if (env_cnt_r < ENV_MAX) begin
            env_cnt_r <= env_cnt_r + ENV_ONE;
        end else begin
            env_cnt_r <= env_cnt_r;
        end
    end

    assign env_s      = (env_cnt_r < ENV_MAX);
    assign env_fall_s = env_prev_r & ~env_s;

    // Envelope history for the burst-end (1->0) event.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            env_prev_r <= 1'b0;
        end else begin
            env_prev_r <= env_s;
        end
    end

    // Burst length counter and latch. The opening edge of a burst is what lifts
    // the envelope, so every rising edge between two burst ends belongs to the
    // burst and a burst of N carrier cycles measures exactly N.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            burst_cnt_r <= 8'd0;
            burst_len_r <= 8'd0;
            burst_evt_r <= 1'b0;
        end else if (env_fall_s) begin
            burst_cnt_r <= carrier_rise_s ? 8'd1 : 8'd0;
            burst_len_r <= burst_cnt_r;
            burst_evt_r <= 1'b1;
        end else begin
            if (carrier_rise_s && (burst_cnt_r != 8'hFF)) begin
                burst_cnt_r <= burst_cnt_r + 8'd1;
            end else begin
                burst_cnt_r <= burst_cnt_r;
            end
            burst_len_r <= burst_len_r;
            burst_evt_r <= 1'b0;
        end
    end

    assign is_start_s  = len_match(burst_len_r, START_LEN);
    assign is_carsel_s = len_match(burst_len_r, CARSEL_LEN);
    assign is_one_s    = len_match(burst_len_r, ASSERT_LEN);
    assign is_zero_s   = len_match(burst_len_r, DEASSERT_LEN);

    // Mid-packet silence watchdog; only runs while a packet is in progress.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            gap_cnt_r <= '0;
        end else if ((state_r == ST_IDLE) || env_s) begin
            gap_cnt_r <= '0;
        end else if (gap_cnt_r < GAP_MAX) begin
            gap_cnt_r <= gap_cnt_r + GAP_ONE;
        end else begin
            gap_cnt_r <= gap_cnt_r;
        end
    end

    assign gap_expired_s = (gap_cnt_r == GAP_MAX);

    // ---------------------------------------------------------------------
    // Packet FSM
    // ---------------------------------------------------------------------

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state and per-cycle actions. In each state only the classes
    // expected there are tested, which resolves any overlap between intervals.
    always_comb begin
        next_state_s = state_r;
        err_s        = 1'b0;
        done_s       = 1'b0;
        bit_we_s     = 1'b0;
        bit_val_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (burst_evt_r && is_start_s) begin
                    next_state_s = ST_CARSEL;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_CARSEL: begin
                if (gap_expired_s) begin
                    next_state_s = ST_IDLE;
                    err_s        = 1'b1;
                end else if (burst_evt_r) begin
                    if (is_carsel_s) begin
                        next_state_s = ST_BITS;
                    end else begin
                        next_state_s = ST_IDLE;
                        err_s        = 1'b1;
                    end
                end else begin
                    next_state_s = ST_CARSEL;
                end
            end
            ST_BITS: begin
                if (gap_expired_s) begin
                    next_state_s = ST_IDLE;
                    err_s        = 1'b1;
                end else if (burst_evt_r) begin
                    if (is_one_s || is_zero_s) begin
                        bit_we_s  = 1'b1;
                        bit_val_s = is_one_s;
                        if (bit_idx_r == 2'd3) begin
                            next_state_s = ST_DONE;
                        end else begin
                            next_state_s = ST_BITS;
                        end
                    end else begin
                        next_state_s = ST_IDLE;
                        err_s        = 1'b1;
                    end
                end else begin
                    next_state_s = ST_BITS;
                end
            end
            ST_DONE: begin
                done_s       = 1'b1;
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Data-bit capture: R, L, B, F fill shift_r[0..3] in arrival order.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            bit_idx_r <= 2'd0;
            shift_r   <= 4'd0;
        end else if (state_r != ST_BITS) begin
            bit_idx_r <= 2'd0;
            shift_r   <= shift_r;
        end else if (bit_we_s) begin
            bit_idx_r          <= bit_idx_r + 2'd1;
            shift_r[bit_idx_r] <= bit_val_s;
        end else begin
            bit_idx_r <= bit_idx_r;
            shift_r   <= shift_r;
        end
    end

    // ---------------------------------------------------------------------
    // Bus registers
    // ---------------------------------------------------------------------

    assign cmd_read_s     = (BUS_ADDR == BASE_ADDR)   && !BUS_WE;
    assign status_read_s  = (BUS_ADDR == STATUS_ADDR) && !BUS_WE;
    assign status_write_s = (BUS_ADDR == STATUS_ADDR) &&  BUS_WE;

    // COMMAND / VALID / OVR. A freshly decoded packet beats a coincident clear.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cmd_r   <= 4'd0;
            valid_r <= 1'b0;
            ovr_r   <= 1'b0;
        end else if (done_s) begin
            cmd_r   <= shift_r;
            valid_r <= 1'b1;
            ovr_r   <= ovr_r | valid_r;
        end else if (cmd_read_s || status_write_s) begin
            cmd_r   <= cmd_r;
            valid_r <= 1'b0;
            ovr_r   <= 1'b0;
        end else begin
            cmd_r   <= cmd_r;
            valid_r <= valid_r;
            ovr_r   <= ovr_r;
        end
    end

    // Saturating error counter; a STATUS write beats a coincident error.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            err_cnt_r <= 4'd0;
        end else if (status_write_s) begin
            err_cnt_r <= 4'd0;
        end else if (err_s && (err_cnt_r != 4'hF)) begin
            err_cnt_r <= err_cnt_r + 4'd1;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    // Interrupt flag; a new packet beats a coincident acknowledge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            irq_r <= 1'b0;
        end else if (done_s) begin
            irq_r <= 1'b1;
        end else if (BUS_INTERRUPT_ACK) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= irq_r;
        end
    end

    assign BUS_INTERRUPT_RAISE = irq_r;

    // Registered read data and output enable (values as seen before any clear).
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_oe_r   <= 1'b0;
            rd_data_r <= 8'd0;
        end else if (cmd_read_s) begin
            rd_oe_r   <= 1'b1;
            rd_data_r <= {4'b0000, cmd_r};
        end else if (status_read_s) begin
            rd_oe_r   <= 1'b1;
            rd_data_r <= {valid_r, ovr_r, 2'b00, err_cnt_r};
        end else begin
            rd_oe_r   <= 1'b0;
            rd_data_r <= 8'd0;
        end
    end

    assign BUS_DATA = rd_oe_r ? rd_data_r : 8'hzz;

endmodule

// File: tb/tb_ir_receiver.sv
// -----------------------------------------------------------------------------
// tb_ir_receiver
//   Self-checking bench for ir_receiver. The carrier is scaled to 4 clocks per
//   period and the envelope/gap timeouts are scaled with it, so burst lengths
//   in carrier cycles are identical to the real link. Expected register and
//   interrupt values come from a packet-level model of the decoding rules.
// -----------------------------------------------------------------------------
module tb_ir_receiver;

    localparam logic [7:0] BASE   = 8'h92;
    localparam int         TOL    = 4;
    localparam int         ENV_TO = 12;
    localparam int         GAP_TO = 300;
    localparam int         HALF   = 2;
    localparam int         GAP_CY = 25;
    localparam int         L_START = 191;
    localparam int         L_CAR   = 47;
    localparam int         L_ONE   = 47;
    localparam int         L_ZERO  = 22;

    logic       clk = 1'b0;
    logic       reset;
    logic       ir_in;
    logic [7:0] bus_addr;
    logic       bus_we;
    logic       ack;
    logic       irq;
    wire  [7:0] bus_data;

    ir_receiver #(
        .BASE_ADDR   (BASE),
        .ENV_TIMEOUT (ENV_TO),
        .GAP_TIMEOUT (GAP_TO)
    ) dut (
        .CLK                 (clk),
        .RESET               (reset),
        .IR_IN               (ir_in),
        .BUS_ADDR            (bus_addr),
        .BUS_DATA            (bus_data),
        .BUS_WE              (bus_we),
        .BUS_INTERRUPT_RAISE (irq),
        .BUS_INTERRUPT_ACK   (ack)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    logic irq_seen;

    // Reference model state: packet position 0 = waiting for START,
    // 1 = waiting for car select, 2..5 = data bits R, L, B, F.
    int         m_pos;
    logic [3:0] m_shift;
    logic [3:0] m_cmd;
    logic [3:0] m_err;
    logic       m_valid;
    logic       m_ovr;
    logic       m_irq;

    task automatic check_value(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    function automatic bit near(input int len, input int target);
        return (len >= target - TOL) && (len <= target + TOL);
    endfunction

    task automatic model_reset();
        m_pos = 0; m_shift = 4'd0; m_cmd = 4'd0; m_err = 4'd0;
        m_valid = 1'b0; m_ovr = 1'b0; m_irq = 1'b0;
    endtask

    task automatic model_error();
        if (m_err != 4'hF) m_err = m_err + 4'd1;
        m_pos = 0;
    endtask

    task automatic model_burst(input int len);
        if (m_pos == 0) begin
            if (near(len, L_START)) m_pos = 1;
        end else if (m_pos == 1) begin
            if (near(len, L_CAR)) m_pos = 2;
            else model_error();
        end else if (near(len, L_ONE) || near(len, L_ZERO)) begin
            m_shift[m_pos-2] = near(len, L_ONE);
            m_pos++;
            if (m_pos == 6) begin
                if (m_valid) m_ovr = 1'b1;
                m_valid = 1'b1;
                m_cmd   = m_shift;
                m_irq   = 1'b1;
                m_pos   = 0;
            end
        end else begin
            model_error();
        end
    endtask

    task automatic idle_clocks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (irq) irq_seen = 1'b1;
        end
    endtask

    task automatic send_burst(input int len);
        for (int i = 0; i < len; i++) begin
            ir_in = 1'b1; repeat (HALF) @(negedge clk);
            ir_in = 1'b0; repeat (HALF) @(negedge clk);
        end
        idle_clocks(GAP_CY * 2 * HALF);
        model_burst(len);
    endtask

    task automatic send_silence();
        idle_clocks(GAP_TO + 100);
        if (m_pos != 0) model_error();
    endtask

    function automatic int jit(input bit en);
        return en ? int'($urandom_range(0, 2 * TOL)) - TOL : 0;
    endfunction

    task automatic send_packet(input logic [3:0] cmd, input bit en);
        send_burst(L_START + jit(en));
        send_burst(L_CAR + jit(en));
        for (int b = 0; b < 4; b++) send_burst((cmd[b] ? L_ONE : L_ZERO) + jit(en));
    endtask

    task automatic bus_read(input logic [7:0] addr, output logic [7:0] data);
        @(negedge clk); bus_addr = addr; bus_we = 1'b0;
        @(negedge clk); data = bus_data; bus_addr = 8'h00;
    endtask

    task automatic bus_write(input logic [7:0] addr);
        @(negedge clk); bus_addr = addr; bus_we = 1'b1;
        @(negedge clk); bus_addr = 8'h00; bus_we = 1'b0;
        if (addr == BASE + 8'd1) begin
            m_valid = 1'b0; m_ovr = 1'b0; m_err = 4'd0;
        end
    endtask

    task automatic check_status(input string tag);
        logic [7:0] d;
        bus_read(BASE + 8'd1, d);
        check_value(tag, d, {m_valid, m_ovr, 2'b00, m_err});
    endtask

    task automatic check_cmd(input string tag);
        logic [7:0] d;
        bus_read(BASE, d);
        check_value(tag, d, {4'h0, m_cmd});
        m_valid = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic check_irq(input string tag);
        check_value(tag, {7'd0, irq}, {7'd0, m_irq});
    endtask

    task automatic do_ack();
        @(negedge clk); ack = 1'b1;
        @(negedge clk); ack = 1'b0;
        m_irq = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [3:0] rc;
        ir_in = 1'b0; bus_addr = 8'h00; bus_we = 1'b0; ack = 1'b0; irq_seen = 1'b0;
        apply_reset();
        check_irq("reset_irq");
        check_status("reset_status");
        check_cmd("reset_cmd");

        // Reference packet F=1 B=0 L=0 R=1.
        send_burst(191); send_burst(47); send_burst(47);
        send_burst(22);  send_burst(22); send_burst(47);
        check_irq("p1_irq");
        check_value("p1_model_cmd", {4'h0, m_cmd}, 8'h09);
        check_status("p1_status");
        check_cmd("p1_cmd");
        check_status("p1_status_after_read");
        do_ack();
        check_irq("p1_irq_acked");

        // Short start burst: everything that follows is ignored silently.
        send_burst(120); send_burst(47); send_burst(47);
        send_burst(22);  send_burst(22); send_burst(47);
        check_status("short_start_status");
        check_irq("short_start_irq");

        // Bad bit after a valid header, then a good packet.
        send_burst(191); send_burst(47); send_burst(35);
        check_status("bad_bit_status");
        send_packet(4'h6, 1'b0);
        check_irq("recover_irq");
        check_cmd("recover_cmd");
        do_ack();

        // Interval edges: exactly +/-TOL accepted, TOL+1 rejected.
        send_burst(187); send_burst(51); send_burst(43);
        send_burst(26);  send_burst(18); send_burst(51);
        check_cmd("edge_cmd");
        do_ack();
        send_burst(196); send_burst(47);
        check_status("start_over_edge");
        send_burst(195); send_burst(43); send_burst(52);
        check_status("one_over_edge");

        // Writes to COMMAND are ignored.
        bus_write(BASE);
        check_status("cmd_write_status");
        bus_write(BASE + 8'd1);
        check_status("status_write_clear");

        // Overrun: two packets without a read.
        send_packet(4'h3, 1'b0);
        send_packet(4'hC, 1'b0);
        check_status("ovr_status");
        check_cmd("ovr_cmd");
        bus_write(BASE + 8'd1);
        check_status("ovr_cleared");
        do_ack();

        // Mid-packet silence aborts; err_cnt saturates.
        irq_seen = 1'b0;
        for (int k = 0; k < 16; k++) begin
            send_burst(191); send_burst(47); send_burst(22); send_burst(22);
            send_silence();
            if (k == 0) check_status("abort_first");
        end
        check_status("abort_saturated");
        check_value("abort_no_irq", {7'd0, irq_seen}, 8'd0);

        // Reset in the middle of the data bits.
        send_packet(4'h5, 1'b0);
        send_burst(191); send_burst(47); send_burst(47); send_burst(22);
        apply_reset();
        check_irq("midreset_irq");
        check_status("midreset_status");
        check_cmd("midreset_cmd");
        idle_clocks(50);
        send_packet(4'hA, 1'b0);
        check_cmd("post_reset_cmd");
        check_irq("post_reset_irq");
        do_ack();

        // Acknowledge held across the DONE cycle: raise wins for that cycle.
        send_burst(191); send_burst(47); send_burst(47); send_burst(47); send_burst(22);
        irq_seen = 1'b0;
        ack = 1'b1;
        send_burst(22);
        ack = 1'b0;
        m_irq = 1'b0;
        check_value("ack_in_done_raised", {7'd0, irq_seen}, 8'd1);
        check_irq("ack_in_done_after");
        check_cmd("ack_in_done_cmd");

        // Randomised packets, corrupted packets and register accesses.
        for (int r = 0; r < 8; r++) begin
            rc = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
                send_burst(L_START + jit(1'b1));
                send_burst(L_CAR + jit(1'b1));
                send_burst(int'($urandom_range(30, 40)));
            end else begin
                send_packet(rc, 1'b1);
            end
            check_irq("rnd_irq");
            case ($urandom_range(0, 2))
                0: check_cmd("rnd_cmd");
                1: check_status("rnd_status");
                default: begin
                    bus_write(BASE + 8'd1);
                    check_status("rnd_clear");
                end
            endcase
            do_ack();
        end
        check_status("final_status");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
